// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer for a single-port data RAM (combinational read, synchronous write).
// Accepts byte addresses, rejects misaligned/out-of-range accesses, one access per IDLE-ACCESS-RESP pass.
module ram_port_arbiter #(
   parameter int RAM_DEPTH = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   output logic        p0_err,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        p1_err,
   output logic        ram_re,
   output logic        ram_we,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_wdata,
   input  logic [31:0] ram_rdata
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_ACCESS = 2'd1;
   localparam logic [1:0]  S_RESP   = 2'd2;
   localparam logic [33:0] ADDR_LIM = 34'(RAM_DEPTH) << 2;

   logic [1:0]  r_state;
   logic        r_last;
   logic        r_port;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;

   logic w_idle;
   logic w_gnt0;
   logic w_gnt1;
   logic w_err;
   logic w_ram_go;
   logic w_resp;

   assign w_idle = (r_state == S_IDLE);
   // Round-robin: on contention the port that did not win last time gets the grant.
   assign w_gnt0 = ~rst & w_idle & p0_req & (~p1_req | r_last);
   assign w_gnt1 = ~rst & w_idle & p1_req & (~p0_req | ~r_last);
   assign w_err  = (r_addr[1:0] != 2'b00) || ({2'b00, r_addr} >= ADDR_LIM);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_last  <= 1'b1;
         r_port  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt0 | w_gnt1) begin
                  r_state <= S_ACCESS;
                  r_last  <= w_gnt1;
                  r_port  <= w_gnt1;
                  r_we    <= w_gnt1 ? p1_we    : p0_we;
                  r_addr  <= w_gnt1 ? p1_addr  : p0_addr;
                  r_wdata <= w_gnt1 ? p1_wdata : p0_wdata;
               end
            end
            S_ACCESS: begin
               r_state <= S_RESP;
               r_rdata <= (w_err | r_we) ? 32'd0 : ram_rdata;
            end
            S_RESP:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // The RAM is only driven during a legal ACCESS; a reset in that cycle suppresses the write.
   assign w_ram_go  = (r_state == S_ACCESS) & ~w_err;
   assign ram_re    = w_ram_go & ~r_we;
   assign ram_we    = w_ram_go & r_we & ~rst;
   assign ram_addr  = w_ram_go ? {2'b00, r_addr[31:2]} : 32'd0;
   assign ram_wdata = w_ram_go ? r_wdata : 32'd0;

   assign w_resp    = (r_state == S_RESP) & ~rst;
   assign p0_gnt    = w_gnt0;
   assign p1_gnt    = w_gnt1;
   assign p0_rvalid = w_resp & ~r_port;
   assign p1_rvalid = w_resp & r_port;
   assign p0_rdata  = p0_rvalid ? r_rdata : 32'd0;
   assign p1_rdata  = p1_rvalid ? r_rdata : 32'd0;
   assign p0_err    = p0_rvalid & w_err;
   assign p1_err    = p1_rvalid & w_err;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural 256-word RAM attached.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req, p0_we, p1_req, p1_we;
   logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0] p0_rdata, p1_rdata;
   logic        ram_re, ram_we;
   logic [31:0] ram_addr, ram_wdata, ram_rdata;
   logic [31:0] mem [256];

   int total = 0;
   int bad   = 0;

   ram_port_arbiter #(.RAM_DEPTH(256)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
      .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
      .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
      .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
      .ram_re(ram_re), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   assign ram_rdata = mem[ram_addr[7:0]];
   always @(posedge clk) if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // One uncontended access; inputs are dropped/scrambled right after the grant.
   task automatic access1(input int port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
      logic [31:0] rd;
      logic        vl, er;
      @(negedge clk);
      if (port == 0) begin
         p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wd;
      end else begin
         p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wd;
      end
      #1;
      chk("gnt", {30'd0, p1_gnt, p0_gnt}, (port == 0) ? 32'd1 : 32'd2);
      chk("idle_ram_re", {31'd0, ram_re}, 32'd0);
      @(negedge clk);
      p0_req = 1'b0; p1_req = 1'b0;
      p0_addr = ~addr; p1_addr = ~addr; p0_wdata = 32'h0; p1_wdata = 32'h0;
      p0_we = ~we; p1_we = ~we;
      #1;
      chk("acc_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("acc_re", {31'd0, ram_re}, exp_err ? 32'd0 : {31'd0, ~we});
      chk("acc_we", {31'd0, ram_we}, exp_err ? 32'd0 : {31'd0, we});
      chk("acc_addr", ram_addr, exp_err ? 32'd0 : (addr >> 2));
      chk("acc_wdata", ram_wdata, exp_err ? 32'd0 : wd);
      @(negedge clk);
      #1;
      rd = (port == 0) ? p0_rdata : p1_rdata;
      vl = (port == 0) ? p0_rvalid : p1_rvalid;
      er = (port == 0) ? p0_err : p1_err;
      chk("rvalid", {31'd0, vl}, 32'd1);
      chk("other_rvalid", {31'd0, (port == 0) ? p1_rvalid : p0_rvalid}, 32'd0);
      chk("err", {31'd0, er}, {31'd0, exp_err});
      chk("rdata", rd, exp_rd);
      chk("resp_ram", {30'd0, ram_re, ram_we}, 32'd0);
   endtask

   // One step of a contended sequence; both reqs are held by the caller.
   task automatic cstep(input int w, input logic [31:0] exp_rd);
      @(negedge clk); #1;
      chk("c_gnt", {30'd0, p1_gnt, p0_gnt}, (w == 0) ? 32'd1 : 32'd2);
      @(negedge clk); #1;
      chk("c_acc_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      @(negedge clk); #1;
      chk("c_rvalid", {30'd0, p1_rvalid, p0_rvalid}, (w == 0) ? 32'd1 : 32'd2);
      chk("c_rdata", (w == 0) ? p0_rdata : p1_rdata, exp_rd);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4; p1_wdata = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      chk("rst_ram", {30'd0, ram_re, ram_we}, 32'd0);
      chk("rst_addr", ram_addr, 32'd0);
      chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
      p0_req = 1'b0; p1_req = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // write then read back through port 0
      access1(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
      access1(0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);
      // misaligned, out of range, last legal word
      access1(1, 1'b0, 32'h13, 32'h0, 1'b1, 32'h0);
      access1(0, 1'b1, 32'h400, 32'h55, 1'b1, 32'h0);
      access1(0, 1'b1, 32'h3FC, 32'hA5A5A5A5, 1'b0, 32'h0);
      access1(1, 1'b0, 32'h3FC, 32'h0, 1'b0, 32'hA5A5A5A5);
      access1(1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

      // contention from reset: 0,1,0,1
      @(negedge clk);
      rst = 1'b1;
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14;
      @(posedge clk); #1 rst = 1'b0;
      cstep(0, 32'hDEADBEEF);
      cstep(1, 32'h1005);
      cstep(0, 32'hDEADBEEF);
      cstep(1, 32'h1005);
      p0_req = 1'b0; p1_req = 1'b0;

      // reset during the ACCESS cycle of a write to 0x20
      @(negedge clk);
      p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_wdata = 32'h12345678;
      #1 chk("mid_gnt", {31'd0, p0_gnt}, 32'd1);
      @(negedge clk);
      rst = 1'b1; p0_req = 1'b0;
      #1 chk("mid_ram_we", {31'd0, ram_we}, 32'd0);
      @(negedge clk); #1;
      chk("mid_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
      p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h20;
      p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h14;
      @(posedge clk); #1 rst = 1'b0;
      cstep(0, 32'h1008);
      p0_req = 1'b0; p1_req = 1'b0;
      access1(1, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1008);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port data RAM. The RAM has a combinational read, a synchronous write and word-indexed addressing.
- Port 0 serves the load/store unit; port 1 serves the debug/program loader.
- The block takes byte addresses, checks alignment and range, serializes accesses through a 3-state FSM, and returns registered read data with per-port valid/error.

Parameters:
- RAM_DEPTH, 256, number of 32-bit words in the attached RAM; legal byte addresses are 0 .. 4*RAM_DEPTH-1.

Ports:
- clk  input  1  clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- p0_req  input  1  port 0 access request; held until p0_gnt
- p0_we  input  1  port 0: 1=write, 0=read
- p0_addr  input  32  port 0 byte address
- p0_wdata  input  32  port 0 write data
- p0_gnt  output  1  port 0 request accepted this cycle
- p0_rvalid  output  1  port 0 response valid, 1-cycle pulse
- p0_rdata  output  32  port 0 read data, valid with p0_rvalid
- p0_err  output  1  port 0 access rejected, valid with p0_rvalid
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: same directions, widths and meanings for port 1
- ram_re  output  1  RAM read enable
- ram_we  output  1  RAM write enable
- ram_addr  output  32  RAM word index (byte address >> 2)
- ram_wdata  output  32  RAM write data
- ram_rdata  input  32  RAM combinational read data

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
  - IDLE -> ACCESS when any req is high.
  - ACCESS -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
  - Throughput: one access per 3 cycles; reqs are not sampled in ACCESS or RESP.
- Arbitration happens in IDLE only. gnt is combinational from the reqs, state and last_grant, and at most one gnt is high.
  - Single requester: that port wins.
  - Both requesting: the port != last_grant wins (round-robin).
  - last_grant resets to 1, so port 0 wins the first contended cycle. It updates to the winner on every grant.
- On grant, the winner's we, addr, wdata and port id are latched into internal registers. The requester may drop or change its inputs from the next cycle.
- Error check on the latched address: err = (addr[1:0] != 0) or (addr >= 4*RAM_DEPTH).
- ACCESS cycle:
  - No error: ram_re = ~we, ram_we = we, ram_addr = addr >> 2 (zero-extended to 32 bits), ram_wdata = latched wdata.
  - No error and read: ram_rdata is captured into rdata_q at the end of the cycle.
  - Error: ram_re = ram_we = 0 and rdata_q = 0.
  - Writes also set rdata_q = 0.
- RESP cycle:
  - The winner's rvalid = 1 for exactly one cycle, rdata = rdata_q, err = latched err.
  - The other port's rvalid = 0.
- Outputs outside their valid windows:
  - ram_re, ram_we, ram_addr, ram_wdata are 0 whenever the state is not ACCESS.
  - pX_rdata and pX_err are 0 whenever pX_rvalid = 0.
- Latency: the grant is in cycle N, the RAM operation in N+1, the response in N+2. Write data is in the RAM after the posedge ending N+1.
- Reset values (all outputs 0):
  - state = IDLE, last_grant = 1, latched registers = 0, rdata_q = 0.
  - gnt is 0 during any cycle in which rst = 1.
- Reset mid-operation: the pending access is dropped and no rvalid is issued. If rst is high during ACCESS, ram_we is forced to 0 that cycle, so no write happens.
- A req that stays high after its grant is treated as a new request at the next IDLE.
- Back-to-back contention alternates winners: 0, 1, 0, 1, …

Test Plan:
- Single write then read, port 0: write 0xDEADBEEF to 0x10 (gnt cycle N; ram_we=1, ram_addr=4 at N+1; p0_rvalid=1, err=0 at N+2). Then read 0x10 -> p0_rdata=0xDEADBEEF at N+2 of the read.
- Contention: p0_req and p1_req held high from reset for 4 accesses -> grants go 0, 1, 0, 1, 3 cycles apart. Each rvalid appears on the matching port only.
- Misaligned: p1 reads 0x13 -> ram_re=0 and ram_we=0 throughout; p1_rvalid=1, p1_err=1, p1_rdata=0.
- Out of range with RAM_DEPTH=256: p0 writes 0x400 -> err=1 and no ram_we. Address 0x3FC is accepted with err=0 and ram_addr=255.
- Reset mid-op: rst asserted during ACCESS of a write to 0x20 -> ram_we=0, no rvalid, and a later read of 0x20 returns the old value. After release, the next contended grant goes to port 0.
- Req hold: p0 drops req 1 cycle after gnt and changes addr -> the access uses the originally latched address.
